serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The module SHALL have parameter m, default 32, operand width in bits; legal values are multiples of 4, at least 8.
REQ-002 The module SHALL have a fixed local constant n = 4, the bits processed per cycle; it SHALL NOT be overridable.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1, meaning operands are presented.
REQ-006 The module SHALL have port in_ready, output, 1, meaning the block accepts operands this cycle.
REQ-007 The module SHALL have ports A and B, input, m each, the minuend and subtrahend.
REQ-008 The module SHALL have port Bin, input, 1, the borrow-in.
REQ-009 The module SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-010 The module SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The module SHALL have port D, output, m, the difference A - B - Bin mod 2^m.
REQ-012 The module SHALL have port Bout, output, 1, the borrow-out: 1 iff unsigned A < B + Bin.
REQ-013 The module SHALL have port V, output, 1, the signed overflow of the two's-complement subtraction.
REQ-014 The module SHALL have port Z, output, 1, high iff D == 0.

Function
REQ-015 The module SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 In IDLE with in_valid=1, the module SHALL capture A, B and Bin, clear the nibble counter, and go to BUSY.
REQ-019 In BUSY, each cycle the module SHALL subtract nibble k (bits 4k+3:4k) using the registered borrow and store the 4-bit result into D bits 4k+3:4k.
REQ-020 The borrow register SHALL be loaded with Bin at acceptance and SHALL be updated with the nibble borrow-out each BUSY cycle.
REQ-021 BUSY SHALL last exactly m/4 cycles; after the last nibble the FSM SHALL go to DONE.
REQ-022 Latency from the accept edge to the first cycle with out_valid=1 SHALL be m/4+1 cycles, i.e. 9 for m=32.
REQ-023 On the last-nibble edge the module SHALL register Bout as the final borrow.
REQ-024 On the last-nibble edge the module SHALL register V = A[m-1] XOR B[m-1] AND A[m-1] XOR D[m-1].
REQ-025 On the last-nibble edge the module SHALL register Z, evaluated on the completed difference.
REQ-026 In DONE, D, Bout, V and Z SHALL stay stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-027 Because in_ready=0 in DONE, the earliest next accept SHALL be the cycle after the out handshake, giving a minimum initiation interval of m/4+2 cycles.
REQ-028 in_valid SHALL be ignored in BUSY and DONE, and the captured operands SHALL be immune to input changes after accept.
REQ-029 out_ready SHALL be ignored outside DONE.
REQ-030 The nibble counter SHALL be ceil(log2(m/4)) bits wide and SHALL never wrap within an operation.
REQ-031 The subtraction SHALL be unsigned modular; Bout and V are independent flags, both valid in the same result.

Reset
REQ-032 When rst_n=0 at any time, including mid-BUSY or in DONE, the module SHALL immediately force state IDLE, in_ready=1, out_valid=0, D=0, Bout=0, V=0, Z=0, counter=0 and borrow=0.
REQ-033 An operation interrupted by reset SHALL be discarded and no result produced.
REQ-034 The first accept SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-035 A shared package SHALL hold the state enum type (IDLE, BUSY, DONE) and the nibble width constant n = 4.
REQ-036 One sub-module sub_bloque SHALL be used: a 4-bit combinational subtractor with inputs a, b, bin and outputs d, bout, instantiated once and time-shared across nibbles.

Verification
REQ-037 Basic: A=0x0000_0005, B=0x0000_0003, Bin=0 -> D=0x0000_0002, Bout=0, V=0, Z=0, out_valid 9 cycles after accept.
REQ-038 Borrow ripple: A=0x0000_0000, B=0x0000_0001, Bin=0 -> D=0xFFFF_FFFF, Bout=1, V=0, Z=0.
REQ-039 Overflow and zero: A=0x8000_0000, B=0x0000_0001 -> D=0x7FFF_FFFF, V=1, Bout=0; then A=B=0x1234_5678, Bin=0 -> D=0, Z=1.
REQ-040 Borrow-in: A=0x0000_0010, B=0x0000_0010, Bin=1 -> D=0xFFFF_FFFF, Bout=1.
REQ-041 Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling A and B -> D and flags stable and in_ready=0 throughout; accept occurs 1 cycle after the out handshake.
REQ-042 Reset mid-op: assert rst_n=0 at BUSY cycle 4 -> all outputs zero immediately, in_ready=1; a new op after release completes correctly.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned n = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_sub_bloque.sv
// 4-bit combinational subtractor slice: {bout, d} = a - b - bin.
module sub_bloque
  import serial_sub_pkg::*;
(
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         bin,
  output logic [n-1:0] d,
  output logic         bout
);

  logic [n:0] diff;

  // The extra top bit goes to 1 exactly when the result is negative.
  assign diff = {1'b0, a} - {1'b0, b} - {{n{1'b0}}, bin};
  assign d    = diff[n-1:0];
  assign bout = diff[n];

endmodule

// File: rtl/serial_sub.sv
// Serial subtractor: computes A - B - Bin one nibble per cycle through a single shared slice,
// with valid/ready handshakes on both sides and registered Bout/V/Z flags.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned m = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [m-1:0] A,
  input  logic [m-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] D,
  output logic         Bout,
  output logic         V,
  output logic         Z
);

  localparam int unsigned NumNib = m / n;
  localparam int unsigned CntW   = $clog2(NumNib);

  state_e                   state_q, state_d;
  logic [NumNib-1:0][n-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     borrow_q, borrow_d;
  logic                     bout_q, bout_d;
  logic                     v_q, v_d;
  logic                     z_q, z_d;

  logic [n-1:0] nib_d;
  logic         nib_bout;
  logic         last_nib;

  sub_bloque u_sub (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (borrow_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  assign last_nib = (cnt_q == CntW'(NumNib - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    v_d      = v_q;
    z_d      = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        d_d[cnt_q] = nib_d;
        borrow_d   = nib_bout;
        if (last_nib) begin
          // Flags are taken from the completed difference, including the nibble written now.
          bout_d  = nib_bout;
          v_d     = (a_q[NumNib-1][n-1] ^ b_q[NumNib-1][n-1]) &
                    (a_q[NumNib-1][n-1] ^ nib_d[n-1]);
          z_d     = (d_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign Bout      = bout_q;
  assign V         = v_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: vector table plus back-pressure and mid-operation reset sequences.
module tb_serial_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
  logic        V;
  logic        Z;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  serial_sub #(.m(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V),
    .Z         (Z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT in IDLE; leaves it back in IDLE after a negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic ev, input logic ez,
                        input int hold);
    int lat;
    bit seen;
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    A         = a;
    B         = b;
    Bin       = bin;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    lat       = 0;
    seen      = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("in_ready_low_after_accept", {31'b0, in_ready}, 32'd0);
      // Scramble inputs after accept; captured operands must not follow them.
      A        = $urandom;
      B        = $urandom;
      Bin      = 1'($urandom);
      in_valid = 1'b1;
      if (out_valid) seen = 1'b1;
    end
    check("latency", lat, 32'd9);
    check("D", D, ed);
    check("Bout", {31'b0, Bout}, {31'b0, eb});
    check("V", {31'b0, V}, {31'b0, ev});
    check("Z", {31'b0, Z}, {31'b0, ez});
    check("in_ready_done", {31'b0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      A        = $urandom;
      B        = $urandom;
      in_valid = 1'b1;
      check("hold_D", D, ed);
      check("hold_flags", {29'b0, Bout, V, Z}, {29'b0, eb, ev, ez});
      check("hold_valid_ready", {30'b0, out_valid, in_ready}, 32'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_handshake", {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {D[27:0], out_valid, in_ready, Bout, V | Z},
          {28'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Release and present operands at once: the first rising edge with rst_n high accepts.
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].v, vecs[i].z, 0);
    end

    // Back-pressure, then an immediate follow-on accept right after the out handshake.
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 5);
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);

    // Reset during BUSY cycle 4.
    check("in_ready_pre_reset_op", {31'b0, in_ready}, 32'd1);
    A        = 32'h0000_FFFF;
    B        = 32'h0000_0000;
    Bin      = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_D", D, 32'h0);
    check("reset_mid_ctrl", {27'b0, in_ready, out_valid, Bout, V, Z}, 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit spurious;
      spurious = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (out_valid) spurious = 1'b1;
      end
      check("no_result_after_reset", {31'b0, spurious}, 32'd0);
    end
    run_op(32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 32'hA5A4_A5A6, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
